instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory read interface: owns the program counter, drives the
//  word address into the combinational instruction ROM and captures the returned 32-bit word.
//  Presents {instr, pc} to the decode stage via a valid/ready IF/ID register with stall and
//  redirect (branch/jump) support. Sits between the instruction ROM and the decoder/control unit.
// PARAMETERS
//  ADDR_W    8    width of word address / PC (ROM is word-indexed, 2**ADDR_W words)
//  DATA_W    32   instruction width
//  RESET_PC  0    PC value loaded on reset
// PORTS
//  clk             in   1       single clock; all state updates on rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  start           in   1       1-cycle pulse: leave IDLE and begin fetching
//  imem_addr       out  ADDR_W  word address to instruction ROM (= PC register, direct)
//  imem_rdata      in   DATA_W  ROM read data, combinational from imem_addr (same cycle)
//  redirect_valid  in   1       load new PC and flush IF/ID this cycle
//  redirect_addr   in   ADDR_W  new PC word address
//  out_valid       out  1       IF/ID register holds a valid instruction
//  out_ready       in   1       decode accepts IF/ID contents this cycle
//  out_instr       out  DATA_W  fetched instruction
//  out_pc          out  ADDR_W  word address the instruction was fetched from
//  running         out  1       state == RUN
//  halted          out  1       state == HALT (constant 0 without IFU_HALT_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0,
//    running=0, halted=0. Takes effect immediately, mid-fetch included; no partial transfer survives.
//  - States: IDLE -> RUN when start=1 (sampled at edge). RUN -> HALT only with IFU_HALT_EN.
//    HALT exits only via reset. start ignored outside IDLE.
//  - IDLE: pc held, no capture, out_valid=0; redirect_valid in IDLE loads pc, stays IDLE.
//  - RUN, accept = (!out_valid || out_ready). Per edge, priority order:
//    1. redirect_valid=1: pc<=redirect_addr, out_valid<=0 (flush), regardless of out_ready.
//    2. accept=1: out_instr<=imem_rdata, out_pc<=pc, out_valid<=1, pc<=pc+1.
//    3. else (stall): pc, out_instr, out_pc, out_valid held stable.
//  - Handshake: transfer occurs on an edge with out_valid && out_ready; out_* must not change
//    while out_valid=1 && out_ready=0 except via redirect flush or reset.
//  - Latency: word at address A appears on out_instr 1 cycle after pc==A with accept=1.
//    Throughput 1 instr/cycle when out_ready held high. First capture in first RUN cycle.
//  - PC arithmetic modulo 2**ADDR_W: pc=2**ADDR_W-1 increments to 0 (wrap, no flag).
//  - Redirect and accept in same cycle: redirect wins; the word at old pc is discarded.
//  - Addresses beyond the ROM program return 0 (nop); fetched and delivered like any word.
// CONFIGURATION
//  IFU_HALT_EN defined: in RUN, when accept=1 and imem_rdata==32'h0000_000C (SPECIAL/syscall),
//    the word is captured and delivered normally, pc is NOT incremented, state->HALT. In HALT:
//    no captures, redirect ignored, pending out_valid still drains on out_ready; halted=1.
//  IFU_HALT_EN undefined: syscall word fetched like any other, HALT unreachable, halted tied 0.
// TESTING (ROM: w0=0x20010003, w1=0x20020009, w7=0x200100CA, w12=0x0000000C, others as program)
//  1. Reset, start pulse, out_ready=1 -> imem_addr 0,1,2..; out_valid=1 with out_pc=0,
//     out_instr=0x20010003, next cycle out_pc=1, out_instr=0x20020009; running=1.
//  2. out_ready=0 while out_pc=2 valid for 3 cycles -> out_pc=2/out_instr stable, imem_addr=3 held;
//     out_ready=1 -> out_pc=3 next cycle.
//  3. redirect_valid=1, redirect_addr=7 during stall -> next cycle out_valid=0, imem_addr=7;
//     following cycle out_instr=0x200100CA, out_pc=7.
//  4. redirect_addr=255, out_ready=1 -> out_pc sequence 255, 0, 1 (wrap), no stall bubble.
//  5. rst_n=0 asynchronously mid-RUN with out_valid=1 -> out_valid=0, imem_addr=RESET_PC,
//     running=0 before next clk edge; start required to resume from word 0.
//  6. IFU_HALT_EN: redirect to 12 -> out_instr=0x0000000C, out_pc=12, halted=1, imem_addr stays 12,
//     no further out_valid after drain, redirect_valid ignored. Undefined: out_pc continues 13,14.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Owns the program counter, drives the word address into a combinational
//   instruction ROM and registers the returned word together with its address
//   into a valid/ready IF/ID stage. Supports decode stall and redirect flush.
//
//   Optional feature macro: IFU_HALT_EN
//     When defined, fetching the syscall word 32'h0000_000C delivers it
//     normally and then parks the unit in HALT (exit only via reset).
//     When undefined, the syscall word is an ordinary instruction and
//     halted is tied low.
//
//   Handshake (IF/ID output): out_valid=1 means out_instr/out_pc hold a valid
//   instruction. A transfer happens on a rising edge where out_valid && out_ready.
//   While out_valid=1 && out_ready=0 the outputs stay stable; only a redirect
//   flush or reset may drop them.
//
//   FSM state is observable through running (RUN) and halted (HALT);
//   both low means IDLE.

module instruction_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              running,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
`ifdef IFU_HALT_EN
    localparam logic [DATA_W-1:0] SYSCALL = DATA_W'(32'h0000_000C);
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;

    // The IF/ID register can take a new word when empty or being drained.
    logic accept;
    assign accept = !out_valid_q || out_ready;

    // State and datapath registers; reset acts immediately and drops any
    // in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= PC_RST;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    // Next-state and datapath update: redirect beats capture, capture beats stall.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        case (state_q)
            S_IDLE: begin
                // No fetching here; a redirect only repositions the PC.
                out_valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d = redirect_addr;
                end
                if (start) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (redirect_valid) begin
                    // Flush: the word at the old PC is discarded.
                    pc_d        = redirect_addr;
                    out_valid_d = 1'b0;
                end else if (accept) begin
                    out_instr_d = imem_rdata;
                    out_pc_d    = pc_q;
                    out_valid_d = 1'b1;
                    pc_d        = pc_q + PC_ONE;  // wraps modulo 2**ADDR_W
`ifdef IFU_HALT_EN
                    if (imem_rdata == SYSCALL) begin
                        // Syscall is delivered, then fetching stops at its address.
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
`endif
                end
            end

            S_HALT: begin
                // Only the pending word may still leave; redirects are ignored.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign running   = (state_q == S_RUN);
`ifdef IFU_HALT_EN
    assign halted    = (state_q == S_HALT);
`else
    assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a small combinational ROM model,
// hand-computed expectations, one checking task and a final summary line.

module tb_instruction_fetch_unit;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              running;
    logic              halted;

    instruction_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RESET_PC(0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .running       (running),
        .halted        (halted)
    );

    // ---------------- ROM model ----------------
    function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W-1:0] a);
        case (a)
            8'd0:    rom = 32'h2001_0003;
            8'd1:    rom = 32'h2002_0009;
            8'd2:    rom = 32'h2003_0005;
            8'd3:    rom = 32'h2004_0007;
            8'd4:    rom = 32'h0022_1820;
            8'd7:    rom = 32'h2001_00CA;
            8'd12:   rom = 32'h0000_000C;
            8'd13:   rom = 32'h2005_0001;
            8'd14:   rom = 32'h2006_0002;
            8'd255:  rom = 32'h1234_5678;
            default: rom = 32'h0000_0000;
        endcase
    endfunction
    assign imem_rdata = rom(imem_addr);

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [ADDR_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [ADDR_W-1:0] pc,
                             input logic [DATA_W-1:0] instr, input logic [ADDR_W-1:0] addr);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".pc"},    32'(out_pc),    32'(pc));
        check({tag, ".instr"}, out_instr,      instr);
        check({tag, ".addr"},  32'(imem_addr), 32'(addr));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        out_ready      = 1'b1;

        // Reset state
        #12;
        check("rst.valid",   32'(out_valid), 32'd0);
        check("rst.addr",    32'(imem_addr), 32'd0);
        check("rst.running", 32'(running),   32'd0);
        check("rst.halted",  32'(halted),    32'd0);
        check("rst.instr",   out_instr,      32'd0);
        check("rst.pc",      32'(out_pc),    32'd0);
        rst_n = 1'b1;

        // IDLE without start: nothing fetched
        tick();
        check_out("idle", 1'b0, 8'd0, 32'd0, 8'd0);

        // Test 1: start and stream
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1.running", 32'(running), 32'd1);
        check_out("t1.run0", 1'b0, 8'd0, 32'd0, 8'd0);
        tick();
        check_out("t1.w0", 1'b1, 8'd0, 32'h2001_0003, 8'd1);
        tick();
        check_out("t1.w1", 1'b1, 8'd1, 32'h2002_0009, 8'd2);
        tick();
        check_out("t1.w2", 1'b1, 8'd2, 32'h2003_0005, 8'd3);

        // Test 2: stall 3 cycles on word 2, then release
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("t2.stall", 1'b1, 8'd2, 32'h2003_0005, 8'd3);
        end
        out_ready = 1'b1;
        tick();
        check_out("t2.release", 1'b1, 8'd3, 32'h2004_0007, 8'd4);

        // Test 3: redirect to 7 during a stall
        out_ready = 1'b0;
        tick();
        check_out("t3.stall", 1'b1, 8'd3, 32'h2004_0007, 8'd4);
        redirect_valid = 1'b1;
        redirect_addr  = 8'd7;
        tick();
        redirect_valid = 1'b0;
        check("t3.flush.valid", 32'(out_valid), 32'd0);
        check("t3.flush.addr",  32'(imem_addr), 32'd7);
        out_ready = 1'b1;
        tick();
        check_out("t3.w7", 1'b1, 8'd7, 32'h2001_00CA, 8'd8);

        // Test 4: redirect wins over a same-cycle accept, then wrap 255 -> 0 -> 1
        redirect_valid = 1'b1;
        redirect_addr  = 8'd255;
        tick();
        redirect_valid = 1'b0;
        check("t4.flush.valid", 32'(out_valid), 32'd0);
        check("t4.flush.addr",  32'(imem_addr), 32'd255);
        exp_q.push_back(8'd255);
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd1);
        while (exp_q.size() > 0) begin
            logic [ADDR_W-1:0] e;
            e = exp_q.pop_front();
            tick();
            check("t4.valid", 32'(out_valid), 32'd1);
            check("t4.pc",    32'(out_pc),    32'(e));
            check("t4.instr", out_instr,      rom(e));
        end

        // Test 5: asynchronous reset mid-RUN with a valid word held
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5.valid",   32'(out_valid), 32'd0);
        check("t5.addr",    32'(imem_addr), 32'd0);
        check("t5.running", 32'(running),   32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        check_out("t5.idle", 1'b0, 8'd0, 32'd0, 8'd0);
        check("t5.idle.running", 32'(running), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_out("t5.w0", 1'b1, 8'd0, 32'h2001_0003, 8'd1);

        // Test 6: syscall word at 12
        redirect_valid = 1'b1;
        redirect_addr  = 8'd12;
        tick();
        redirect_valid = 1'b0;
        check("t6.flush.valid", 32'(out_valid), 32'd0);
        check("t6.flush.addr",  32'(imem_addr), 32'd12);
        tick();
`ifdef IFU_HALT_EN
        check_out("t6.sys", 1'b1, 8'd12, 32'h0000_000C, 8'd12);
        check("t6.halted",  32'(halted),  32'd1);
        check("t6.running", 32'(running), 32'd0);
        tick();
        check_out("t6.drain", 1'b0, 8'd12, 32'h0000_000C, 8'd12);
        redirect_valid = 1'b1;
        redirect_addr  = 8'd3;
        tick();
        redirect_valid = 1'b0;
        check_out("t6.redir_ign", 1'b0, 8'd12, 32'h0000_000C, 8'd12);
        check("t6.halted2", 32'(halted), 32'd1);
`else
        check_out("t6.sys", 1'b1, 8'd12, 32'h0000_000C, 8'd13);
        check("t6.halted", 32'(halted), 32'd0);
        tick();
        check_out("t6.w13", 1'b1, 8'd13, 32'h2005_0001, 8'd14);
        tick();
        check_out("t6.w14", 1'b1, 8'd14, 32'h2006_0002, 8'd15);
        check("t6.running", 32'(running), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
